ov5647_sccb_writer: RTL and testbench

- SCCB (I2C-compatible) write master sitting directly downstream of the OV5647 register table.
- Consumes each 24-bit command {reg_addr[15:0], data[7:0]} and writes it to the sensor as a 4-byte SCCB write: device address, reg hi, reg lo, data.
- Pulses taken to advance the table and stops when the table reports finished.
- Also drives the table's resend, honours its waitnull hold, and enforces a post-software-reset delay.

---
 rtl/ov5647_sccb_writer_if.sv | 26 ++
 rtl/ov5647_sccb_writer.sv | 210 +++++++++++++++++++++
 tb/tb_ov5647_sccb_writer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ov5647_sccb_writer_if.sv
// Run control, register-table handshake and SCCB pad signals of the OV5647 write master.
// master = the writer; slave = whatever drives start, the table and the sensor pads.
interface ov5647_sccb_writer_if;
  logic        start;
  logic [23:0] command;
  logic        finished;
  logic        waitnull;
  logic        resend;
  logic        taken;
  logic        sioc;
  logic        siod_oe;
  logic        siod_in;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, command, finished, waitnull, siod_in,
    output resend, taken, sioc, siod_oe, busy, done, error
  );

  modport slave (
    output start, command, finished, waitnull, siod_in,
    input  resend, taken, sioc, siod_oe, busy, done, error
  );
endinterface

// File: rtl/ov5647_sccb_writer.sv
// SCCB write master draining the OV5647 register table: one 4-byte write per command, taken after STOP.
// sioc/siod_oe are registered (one clk behind the FSM); the table is held off by waitnull and by NACK retries.
module ov5647_sccb_writer #(
  parameter logic [7:0]  DEV_ADDR      = 8'h6C,
  parameter int          CLK_DIV       = 125,
  parameter logic [31:0] POST_RST_WAIT = 32'd5_000_000,
  parameter int          MAX_RETRY     = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  ov5647_sccb_writer_if.master ctl
);
  localparam int               DIV_W      = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [31:0]      RETRY_LAST = 32'(4 * CLK_DIV - 1);
  localparam logic [31:0]      RST_LAST   = POST_RST_WAIT - 32'd1;
  localparam logic [7:0]       RETRY_MAX  = 8'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_RESEND, S_SETTLE, S_CHECK, S_START,
    S_BYTE, S_STOP, S_TAKE, S_RSTWAIT, S_RETRY
  } state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div_cnt, div_d;
  logic [1:0]       ph, ph_d;
  logic [3:0]       bit_idx, bit_d;
  logic [1:0]       byte_idx, byte_d;
  logic             nack, nack_d;
  logic             abort, abort_d;
  logic [7:0]       retry_cnt, retry_d;
  logic [31:0]      wait_cnt, wait_d;
  logic [23:0]      shadow, shadow_d;
  logic             sioc_q, sioc_d;
  logic             oe_q, oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             on_bus, tick, tx_bit;
  logic [7:0]       cur_byte;

  assign on_bus = (state == S_START) || (state == S_BYTE) || (state == S_STOP);
  assign tick   = on_bus && (div_cnt == DIV_LAST);

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = DEV_ADDR;
      2'd1:    cur_byte = shadow[23:16];
      2'd2:    cur_byte = shadow[15:8];
      default: cur_byte = shadow[7:0];
    endcase
  end

  // bit_idx 0..7 is MSB first, so the select is 7-bit_idx
  assign tx_bit = cur_byte[~bit_idx[2:0]];

  always_comb begin
    state_d  = state;
    div_d    = '0;
    ph_d     = ph;
    bit_d    = bit_idx;
    byte_d   = byte_idx;
    nack_d   = nack;
    abort_d  = abort;
    retry_d  = retry_cnt;
    wait_d   = wait_cnt + 32'd1;
    shadow_d = shadow;
    done_d   = done_q;
    error_d  = error_q;
    sioc_d   = 1'b1;
    oe_d     = 1'b0;
    if (on_bus && !tick) div_d = div_cnt + 1'b1;

    unique case (state)
      S_IDLE: ;
      S_RESEND: begin
        abort_d = 1'b0;
        state_d = S_SETTLE;
      end
      S_SETTLE: if (wait_cnt == 32'd2) state_d = S_CHECK;
      S_CHECK: begin
        if (ctl.finished) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (!ctl.waitnull) begin
          shadow_d = ctl.command;
          retry_d  = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        oe_d   = 1'b1;
        sioc_d = (ph == 2'd0);
        if (tick) begin
          ph_d = ph + 2'd1;
          if (ph == 2'd1) begin
            state_d = S_BYTE;
            bit_d   = '0;
            byte_d  = '0;
            nack_d  = 1'b0;
          end
        end
      end
      S_BYTE: begin
        sioc_d = ph[1];
        oe_d   = (bit_idx < 4'd8) ? ~tx_bit : 1'b0;
        if (tick) begin
          ph_d = ph + 2'd1;
          if (ph == 2'd2 && bit_idx == 4'd8) nack_d = ctl.siod_in;
          if (ph == 2'd3) begin
            if (bit_idx != 4'd8) begin
              bit_d = bit_idx + 4'd1;
            end else if (nack || byte_idx == 2'd3) begin
              state_d = S_STOP;
            end else begin
              bit_d  = '0;
              byte_d = byte_idx + 2'd1;
            end
          end
        end
      end
      S_STOP: begin
        sioc_d = (ph != 2'd0);
        oe_d   = (ph != 2'd2);
        if (tick && ph == 2'd2) begin
          if (abort || ctl.start) begin
            state_d = S_RESEND;
          end else if (!nack) begin
            state_d = S_TAKE;
          end else if (retry_cnt < RETRY_MAX) begin
            retry_d = retry_cnt + 8'd1;
            state_d = S_RETRY;
          end else begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tick) begin
          ph_d = ph + 2'd1;
        end
      end
      // software reset register: the sensor needs time before it accepts more writes
      S_TAKE:    state_d = (shadow[23:8] == 16'h0103) ? S_RSTWAIT : S_SETTLE;
      S_RSTWAIT: if (wait_cnt == RST_LAST) state_d = S_SETTLE;
      S_RETRY:   if (wait_cnt == RETRY_LAST) state_d = S_START;
      default:   state_d = S_IDLE;
    endcase

    // A restart while on the bus finishes with a STOP before resending the table.
    if (ctl.start) begin
      done_d  = 1'b0;
      error_d = 1'b0;
      if (state == S_START || state == S_BYTE) begin
        state_d = S_STOP;
        abort_d = 1'b1;
      end else if (state == S_STOP) begin
        abort_d = 1'b1;
      end else begin
        state_d = S_RESEND;
      end
    end

    if (state_d != state) begin
      div_d  = '0;
      ph_d   = '0;
      wait_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      ph        <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      nack      <= 1'b0;
      abort     <= 1'b0;
      retry_cnt <= '0;
      wait_cnt  <= '0;
      shadow    <= '0;
      sioc_q    <= 1'b1;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_d;
      div_cnt   <= div_d;
      ph        <= ph_d;
      bit_idx   <= bit_d;
      byte_idx  <= byte_d;
      nack      <= nack_d;
      abort     <= abort_d;
      retry_cnt <= retry_d;
      wait_cnt  <= wait_d;
      shadow    <= shadow_d;
      sioc_q    <= sioc_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ctl.resend  = (state == S_RESEND);
  assign ctl.taken   = (state == S_TAKE);
  assign ctl.busy    = (state != S_IDLE);
  assign ctl.sioc    = sioc_q;
  assign ctl.siod_oe = oe_q;
  assign ctl.done    = done_q;
  assign ctl.error   = error_q;
endmodule

// File: tb/tb_ov5647_sccb_writer.sv
// Directed bench for ov5647_sccb_writer: register-table model, SCCB sensor/monitor, hand-computed expectations.
module tb_ov5647_sccb_writer;
  localparam int CD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ov5647_sccb_writer_if bus ();

  ov5647_sccb_writer #(
    .DEV_ADDR      (8'h6C),
    .CLK_DIV       (CD),
    .POST_RST_WAIT (32'd1000),
    .MAX_RETRY     (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus.master)
  );

  // register table: address cleared by resend, advanced by taken
  logic [23:0] tbl [0:7];
  logic [2:0]  taddr = 3'd0;
  always @(posedge clk) begin
    if (bus.resend) taddr <= 3'd0;
    else if (bus.taken && taddr != 3'd7) taddr <= taddr + 3'd1;
  end
  assign bus.command  = tbl[taddr];
  assign bus.finished = (bus.command == 24'hFFFFFF);

  // sensor + bus monitor, sampled on the falling clock edge
  logic sensor_pull = 1'b0;
  wire  sda = !(bus.siod_oe || sensor_pull);
  assign bus.siod_in = sda;

  logic mon_clr = 1'b0;
  logic nack_all = 1'b0;
  int   nack_budget = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_taken = 1'b0, s;
  int         bitcnt = 0, byte_in_txn = 0, nack_given = 0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] bytes_q [$];
  int         start_q [$], stop_q [$], taken_q [$];
  int         resend_cnt = 0, taken_wide = 0, overlap = 0;

  always @(negedge clk) begin
    s = sda;
    if (mon_clr) begin
      bytes_q.delete(); start_q.delete(); stop_q.delete(); taken_q.delete();
      resend_cnt = 0; taken_wide = 0; overlap = 0; nack_given = 0;
    end
    if (!rst_n) begin
      bitcnt = 0;
      sensor_pull = 1'b0;
    end else begin
      if (bus.sioc && prev_scl && prev_sda && !s) begin
        start_q.push_back(cyc);
        bitcnt = 0; byte_in_txn = 0; sensor_pull = 1'b0;
      end
      if (bus.sioc && prev_scl && !prev_sda && s) stop_q.push_back(cyc);
      if (bus.sioc && !prev_scl) begin
        if (bitcnt < 8) begin
          shreg = {shreg[6:0], s};
          bitcnt++;
        end else begin
          bytes_q.push_back(shreg);
          bitcnt = 0;
          byte_in_txn++;
        end
      end
      if (!bus.sioc && prev_scl) begin
        if (bitcnt == 8 && (nack_all || (byte_in_txn == 1 && nack_given < nack_budget))) begin
          sensor_pull = 1'b0;
          if (!nack_all) nack_given++;
        end else begin
          sensor_pull = (bitcnt == 8);
        end
      end
    end
    if (bus.taken) begin
      taken_q.push_back(cyc);
      if (prev_taken) taken_wide++;
    end
    if (bus.resend) resend_cnt++;
    if (bus.taken && bus.resend) overlap++;
    prev_taken = bus.taken;
    prev_scl   = bus.sioc;
    prev_sda   = s;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q4(input int off);
    if (bytes_q.size() < off + 4) return 32'hDEAD_BEEF;
    return {bytes_q[off], bytes_q[off+1], bytes_q[off+2], bytes_q[off+3]};
  endfunction

  task automatic set_tbl(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    tbl[0] = a; tbl[1] = b; tbl[2] = c;
    for (int i = 3; i < 8; i++) tbl[i] = 24'hFFFFFF;
  endtask

  task automatic clear_logs();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!(bus.done && !bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n >= budget), 32'd0);
  endtask

  function automatic int span(input int a, input int b);
    return (a < 0 || b < 0) ? -1 : b - a;
  endfunction

  initial begin
    int gap, n;
    bus.start    = 1'b0;
    bus.waitnull = 1'b0;
    set_tbl(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'({bus.sioc, bus.siod_oe, bus.busy, bus.done, bus.error, bus.taken, bus.resend}),
        32'b1000000);
    rst_n = 1'b1;

    // single write, all ACKed
    set_tbl(24'h303408, 24'hFFFFFF, 24'hFFFFFF);
    clear_logs(); pulse_start();
    wait_done("t1_timeout", 5000);
    chk("t1_bytes", q4(0), 32'h6C303408);
    chk("t1_nbytes", 32'(bytes_q.size()), 32'd4);
    chk("t1_starts_stops", {16'(start_q.size()), 16'(stop_q.size())}, {16'd1, 16'd1});
    chk("t1_taken_once", 32'(taken_q.size()), 32'd1);
    chk("t1_taken_width", 32'(taken_wide), 32'd0);
    chk("t1_resend", 32'(resend_cnt), 32'd1);
    chk("t1_bus_time", 32'(span(start_q.size() > 0 ? start_q[0] : -1, stop_q.size() > 0 ? stop_q[0] : -1)),
        32'(148 * CD));
    chk("t1_taken_after_stop",
        32'(taken_q.size() > 0 && stop_q.size() > 0 && taken_q[0] > stop_q[0]), 32'd1);
    chk("t1_end_state", 32'({bus.sioc, bus.siod_oe, bus.busy, bus.done, bus.error}), 32'b10010);

    // three-entry table run
    set_tbl(24'h380810, 24'h3A0F58, 24'h4F0001);
    clear_logs(); pulse_start();
    wait_done("t2_timeout", 5000);
    chk("t2_first", q4(0), 32'h6C380810);
    chk("t2_second", q4(4), 32'h6C3A0F58);
    chk("t2_third", q4(8), 32'h6C4F0001);
    chk("t2_taken", 32'(taken_q.size()), 32'd3);
    chk("t2_resend", 32'(resend_cnt), 32'd1);
    chk("t2_overlap", 32'(overlap), 32'd0);
    chk("t2_end_state", 32'({bus.sioc, bus.siod_oe, bus.busy, bus.done, bus.error}), 32'b10010);

    // NACK on the register-high byte twice, then success
    nack_budget = 2;
    set_tbl(24'h5A1234, 24'hFFFFFF, 24'hFFFFFF);
    clear_logs(); pulse_start();
    wait_done("t3_timeout", 5000);
    chk("t3_starts", 32'(start_q.size()), 32'd3);
    chk("t3_retry_bytes", q4(0), 32'h6C5A6C5A);
    chk("t3_final_bytes", q4(4), 32'h6C5A1234);
    chk("t3_taken", 32'(taken_q.size()), 32'd1);
    chk("t3_flags", 32'({bus.done, bus.error}), 32'b10);
    nack_budget = 0;

    // NACK forever: abort after 1 + 3 attempts
    nack_all = 1'b1;
    clear_logs(); pulse_start();
    wait_done("t4_timeout", 5000);
    chk("t4_starts", 32'(start_q.size()), 32'd4);
    chk("t4_addr_only", q4(0), 32'h6C6C6C6C);
    chk("t4_taken", 32'(taken_q.size()), 32'd0);
    chk("t4_flags", 32'({bus.done, bus.error, bus.busy}), 32'b110);
    nack_all = 1'b0;

    // waitnull hold in CHECK
    bus.waitnull = 1'b1;
    set_tbl(24'h303408, 24'hFFFFFF, 24'hFFFFFF);
    clear_logs(); pulse_start();
    repeat (200) @(posedge clk);
    #1;
    chk("t5_held", 32'({16'(start_q.size()), 15'd0, bus.busy}), 32'd1);
    gap = cyc;
    bus.waitnull = 1'b0;
    n = 0;
    while (start_q.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start_seen", 32'(start_q.size()), 32'd1);
    gap = (start_q.size() > 0) ? start_q[0] - gap : -1;
    chk("t5_start_gap", 32'(gap >= 1 && gap <= 4), 32'd1);
    wait_done("t5_timeout", 5000);

    // software reset register followed by a normal write
    set_tbl(24'h010301, 24'h303408, 24'hFFFFFF);
    clear_logs(); pulse_start();
    wait_done("t6_timeout", 6000);
    chk("t6_taken", 32'(taken_q.size()), 32'd2);
    gap = (start_q.size() > 1 && taken_q.size() > 0) ? start_q[1] - taken_q[0] : -1;
    chk("t6_rst_wait", 32'(gap >= 1000 && gap <= 1010), 32'd1);
    chk("t6_second", q4(4), 32'h6C303408);

    // reset mid-byte, then a clean run
    set_tbl(24'h303408, 24'hFFFFFF, 24'hFFFFFF);
    clear_logs(); pulse_start();
    n = 0;
    while (bytes_q.size() == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t7_first_byte", 32'(bytes_q.size()), 32'd1);
    repeat (6 * CD) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_rst", 32'({bus.sioc, bus.siod_oe, bus.busy, bus.taken, bus.done, bus.error}), 32'b100000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs(); pulse_start();
    wait_done("t7_timeout", 5000);
    chk("t7_bytes", q4(0), 32'h6C303408);
    chk("t7_counts", {8'(start_q.size()), 8'(stop_q.size()), 8'(taken_q.size()), 8'(resend_cnt)},
        32'h01010101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
